// File: rtl/digit_serial_adder_pkg.sv
// digit_serial_adder shared types and sizing helpers.
// Optional subtract support is enabled with `define SUB_EN.
package digit_serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  function automatic int ndig(input int w, input int d);
    return w / d;
  endfunction

  function automatic int cntw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/digit_serial_adder_if.sv
// Operand/result handshake bundle for digit_serial_adder.
// The sub signal exists only when SUB_EN is defined.
interface digit_serial_adder_if #(
  parameter int WIDTH = 16
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry;

  modport master (
    output in_valid,
    output a,
    output b,
    output cin,
`ifdef SUB_EN
    output sub,
`endif
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  sum,
    input  carry
  );

  modport slave (
    input  in_valid,
    input  a,
    input  b,
    input  cin,
`ifdef SUB_EN
    input  sub,
`endif
    input  out_ready,
    output in_ready,
    output out_valid,
    output sum,
    output carry
  );

endinterface

// File: rtl/digit_serial_adder_add.sv
// digit_add: combinational DIGIT-bit ripple-carry adder slice.
// Built with SUB_EN or without; this cell is mode-agnostic.
module digit_add #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout
);

  always_comb begin
    logic c;
    c = cin;
    s = '0;
    for (int i = 0; i < DIGIT; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/digit_serial_adder.sv
// digit_serial_adder: WIDTH-bit add, DIGIT bits per clock, LSB first.
// Define SUB_EN to add the sub port (a - b - cin as a + ~b + ~cin).
module digit_serial_adder
  import digit_serial_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  digit_serial_adder_if.slave bus
);

  localparam int NDIG = ndig(WIDTH, DIGIT);
  localparam int CW   = cntw(NDIG);
  localparam logic [CW-1:0] KLAST = CW'(NDIG - 1);

  state_t           r_state;
  logic [CW-1:0]    r_k;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_sum;
  logic             r_c;
  logic             r_carry;
  logic             r_in_ready;
  logic             r_out_valid;

  logic [DIGIT-1:0] w_bd;
  logic [DIGIT-1:0] w_s;
  logic             w_co;
  logic [WIDTH-1:0] w_res;

`ifdef SUB_EN
  logic r_sub;
  assign w_bd = r_b[DIGIT-1:0] ^ {DIGIT{r_sub}};
`else
  assign w_bd = r_b[DIGIT-1:0];
`endif

  digit_add #(
    .DIGIT (DIGIT)
  ) u_add (
    .a    (r_a[DIGIT-1:0]),
    .b    (w_bd),
    .cin  (r_c),
    .s    (w_s),
    .cout (w_co)
  );

  // New digit enters at the top; after NDIG shifts digit 0 sits at the bottom.
  generate
    if (NDIG == 1) begin : g_one
      assign w_res = w_s;
    end else begin : g_many
      assign w_res = {w_s, r_res[WIDTH-1:DIGIT]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_k         <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_res       <= '0;
      r_sum       <= '0;
      r_c         <= 1'b0;
      r_carry     <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
`ifdef SUB_EN
      r_sub       <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_a        <= bus.a;
            r_b        <= bus.b;
            r_k        <= '0;
`ifdef SUB_EN
            r_sub      <= bus.sub;
            r_c        <= bus.cin ^ bus.sub;
`else
            r_c        <= bus.cin;
`endif
            r_in_ready <= 1'b0;
            r_state    <= RUN;
          end
        end
        RUN: begin
          r_a   <= r_a >> DIGIT;
          r_b   <= r_b >> DIGIT;
          r_res <= w_res;
          r_c   <= w_co;
          r_k   <= r_k + 1'b1;
          if (r_k == KLAST) begin
            r_sum       <= w_res;
            r_carry     <= w_co;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.sum       = r_sum;
  assign bus.carry     = r_carry;

endmodule

// File: tb/tb_digit_serial_adder.sv
// Scoreboard bench for digit_serial_adder, WIDTH=16 DIGIT=4.
// Subtract scenarios run when SUB_EN is defined.
module tb_digit_serial_adder;

  logic clk;
  logic rst_n;

  digit_serial_adder_if #(.WIDTH(16)) ifc ();

  digit_serial_adder #(
    .WIDTH (16),
    .DIGIT (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  logic [16:0] q[$];
  logic [16:0] last_res = '0;
  bit rnd_done = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  // Reference: plain integer arithmetic, carry = bit 16 / no-borrow.
  function automatic logic [16:0] model(input logic [15:0] a,
                                        input logic [15:0] b,
                                        input logic ci,
                                        input logic sb);
    int unsigned ia, ib, ic;
    logic [16:0] r;
    ia = a;
    ib = b;
    ic = ci;
    if (sb) begin
      r[15:0] = 16'(ia - ib - ic);
      r[16]   = (ia >= ib + ic);
    end else begin
      r = 17'(ia + ib + ic);
    end
    return r;
  endfunction

  task automatic send(input logic [15:0] a,
                      input logic [15:0] b,
                      input logic ci,
                      input logic sb);
    int n;
    n = 0;
    @(negedge clk);
    while (!ifc.in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!ifc.in_ready) begin
      chk("in_ready_timeout", 0, 1);
      return;
    end
    ifc.in_valid = 1'b1;
    ifc.a   = a;
    ifc.b   = b;
    ifc.cin = ci;
`ifdef SUB_EN
    ifc.sub = sb;
`endif
    q.push_back(model(a, b, ci, sb));
    @(negedge clk);
    ifc.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    #2;
    chk("drain", q.size(), 0);
  endtask

  task automatic wait_ov(output int n);
    n = 0;
    while (!ifc.out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin : monitor
    logic [16:0] e;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n && ifc.out_valid && ifc.out_ready) begin
        if (q.size() == 0) begin
          chk("spurious_out", 1, 0);
        end else begin
          e = q.pop_front();
          chk("result", {ifc.carry, ifc.sum}, e);
          last_res = e;
        end
      end
    end
  end

  initial begin : stim
    int n;
    logic [16:0] e;
    rst_n = 1'b0;
    ifc.in_valid  = 1'b0;
    ifc.a         = '0;
    ifc.b         = '0;
    ifc.cin       = 1'b0;
`ifdef SUB_EN
    ifc.sub       = 1'b0;
`endif
    ifc.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_vals",
        {ifc.in_ready, ifc.out_valid, ifc.carry, ifc.sum},
        {1'b1, 1'b0, 1'b0, 16'h0000});
    @(negedge clk);
    rst_n = 1'b1;

    send(16'h1234, 16'h4321, 1'b0, 1'b0);
    wait_ov(n);
    chk("latency", n, 4);
    drain();

    send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    send(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
    send(16'h0000, 16'h0000, 1'b0, 1'b0);
    drain();

`ifdef SUB_EN
    send(16'h0005, 16'h0007, 1'b0, 1'b1);
    send(16'h0007, 16'h0005, 1'b1, 1'b1);
    drain();
`endif

    ifc.out_ready = 1'b0;
    send(16'hA5A5, 16'h0F0F, 1'b1, 1'b0);
    e = model(16'hA5A5, 16'h0F0F, 1'b1, 1'b0);
    wait_ov(n);
    chk("bp_ov_seen", n < 100, 1);
    ifc.in_valid = 1'b1;
    ifc.a = 16'h8001;
    ifc.b = 16'h7FFF;
    ifc.cin = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      chk("bp_hold",
          {ifc.in_ready, ifc.out_valid, ifc.carry, ifc.sum},
          {1'b0, 1'b1, e});
    end
    ifc.in_valid = 1'b0;
    ifc.out_ready = 1'b1;
    send(16'h8001, 16'h7FFF, 1'b0, 1'b0);
    drain();

    send(16'h1111, 16'h2222, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    chk("sum_hold_run", {ifc.carry, ifc.sum}, last_res);
    rst_n = 1'b0;
    #1;
    chk("reset_midrun",
        {ifc.in_ready, ifc.out_valid, ifc.carry, ifc.sum},
        {1'b1, 1'b0, 1'b0, 16'h0000});
    void'(q.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    send(16'h00FF, 16'h0001, 1'b0, 1'b0);
    drain();

    fork
      begin
        logic sb;
        for (int i = 0; i < 40; i++) begin
          sb = 1'b0;
`ifdef SUB_EN
          sb = 1'($urandom_range(0, 1));
`endif
          send(16'($urandom), 16'($urandom),
               1'($urandom_range(0, 1)), sb);
        end
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          @(negedge clk);
          ifc.out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    ifc.out_ready = 1'b1;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
